// File: rtl/obi_pkg.sv
// Shared OBI definitions for the RAM secondary and its byte-writable RAM.
// Contents:
//   OBI_AW / OBI_DW / OBI_BEW : address, data and byte-enable widths
//   obi_req_t                 : request attributes sampled on the accept edge
//   obi_rsp_t                 : response payload (read data + error flag)
//   obi_state_e               : grant FSM states
package obi_pkg;

  localparam int OBI_AW  = 32;
  localparam int OBI_DW  = 32;
  localparam int OBI_BEW = 4;

  typedef struct packed {
    logic [OBI_AW-1:0]  addr;
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  typedef struct packed {
    logic [OBI_DW-1:0] rdata;
    logic              err;
  } obi_rsp_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } obi_state_e;

endpackage

// File: rtl/obi_byte_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port. Kept separate so a technology RAM can be dropped in.
// Ports:
//   clk_i   : clock, rising edge
//   en_i    : access enable for this cycle
//   we_i    : 1 = write the enabled lanes, 0 = load rdata_o from the word
//   idx_i   : word index
//   be_i    : byte enables, bit n covers wdata_i[8n+7:8n]
//   wdata_i : write data
//   rdata_o : read data, updated only by reads, otherwise holds
module obi_byte_ram
  import obi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [OBI_BEW-1:0] be_i,
  input  logic [OBI_DW-1:0]  wdata_i,
  output logic [OBI_DW-1:0]  rdata_o
);

  logic [OBI_DW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int n = 0; n < OBI_BEW; n++) begin
          if (be_i[n]) begin
            mem[idx_i][8*n +: 8] <= wdata_i[8*n +: 8];
          end
        end
      end else begin
        rdata_o <= mem[idx_i];
      end
    end
  end

endmodule

// File: rtl/obi_ram_secondary.sv
// OBI secondary (responder) backed by a byte-writable word RAM.
// Grants after WAIT_CYCLES extra cycles of held req_i and returns exactly one
// response pulse (rvalid_o) in the cycle after each accepted request.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   req_i    : OBI request
//   gnt_o    : OBI grant (combinational from req_i and FSM state)
//   addr_i   : byte address, bits [1:0] ignored
//   we_i     : 1 = write, 0 = read
//   be_i     : byte enables
//   wdata_i  : write data
//   rvalid_o : one-cycle response pulse
//   rdata_o  : read data (0 for writes and errors), holds between responses
//   err_o    : out-of-range flag, holds between responses
module obi_ram_secondary
  import obi_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [OBI_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       WAIT_CYCLES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [OBI_AW-1:0]  addr_i,
  input  logic               we_i,
  input  logic [OBI_BEW-1:0] be_i,
  input  logic [OBI_DW-1:0]  wdata_i,
  output logic               rvalid_o,
  output logic [OBI_DW-1:0]  rdata_o,
  output logic               err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [OBI_AW-1:0] SPAN = OBI_AW'(4 * DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  obi_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt;

  obi_req_t          req_p0;
  logic [OBI_AW-1:0] offset_p0;
  logic              above_base_p0;
  logic              in_range_p0;
  logic              accept_p0;
  logic [IDX_W-1:0]  idx_p0;

  logic              vld_p1;
  logic              err_p1;
  logic              rd_sel_p1;
  logic [OBI_DW-1:0] ram_rdata_p1;
  obi_rsp_t          rsp_p1;

  // Grant FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (!req_i) begin
          // primary withdrew the request: abandon it without any access
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          gnt     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // No grant while reset is held; the first grant follows its release.
  assign gnt_o = gnt && !rst_i;

  // Stage p0: accept and decode
  assign req_p0    = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
  assign accept_p0 = req_i && gnt_o;
  assign offset_p0 = req_p0.addr - BASE_ADDR;

  if (BASE_ADDR == '0) begin : g_base_zero
    assign above_base_p0 = 1'b1;
  end else begin : g_base_cmp
    assign above_base_p0 = (req_p0.addr >= BASE_ADDR);
  end

  // Comparing the offset rather than addr_i against BASE_ADDR + SPAN keeps the
  // upper bound safe when the window ends at the top of the address space.
  assign in_range_p0 = above_base_p0 && (offset_p0 < SPAN);
  assign idx_p0      = offset_p0[IDX_W+1:2];

  obi_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (accept_p0 && in_range_p0),
    .we_i    (req_p0.we),
    .idx_i   (idx_p0),
    .be_i    (req_p0.be),
    .wdata_i (req_p0.wdata),
    .rdata_o (ram_rdata_p1)
  );

  // Stage p1: response register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
      rd_sel_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        err_p1    <= !in_range_p0;
        rd_sel_p1 <= in_range_p0 && !req_p0.we;
      end
    end
  end

  // The RAM read register only changes on reads, so selecting it with the
  // last response's read flag yields hold-until-next-response behaviour and
  // a zero payload for writes, errors and after reset.
  assign rsp_p1.rdata = rd_sel_p1 ? ram_rdata_p1 : '0;
  assign rsp_p1.err   = err_p1;

  assign rvalid_o = vld_p1;
  assign rdata_o  = rsp_p1.rdata;
  assign err_o    = rsp_p1.err;

endmodule

// File: tb/tb_obi_ram_secondary.sv
// Bench for obi_ram_secondary: two instances (no wait states at base 0, and
// three wait states with a 16-word window at 0x1000), a reference memory
// model, and a scoreboard monitor that matches every rvalid pulse.
module tb_obi_ram_secondary;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [2];
  logic        gnt    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  always #5 clk = ~clk;

  obi_ram_secondary #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk_i (clk), .rst_i (rst), .req_i (req[0]), .gnt_o (gnt[0]),
    .addr_i (addr[0]), .we_i (we[0]), .be_i (be[0]), .wdata_i (wdata[0]),
    .rvalid_o (rvalid[0]), .rdata_o (rdata[0]), .err_o (err[0])
  );

  obi_ram_secondary #(
    .DEPTH_WORDS (16),
    .BASE_ADDR   (32'h0000_1000),
    .WAIT_CYCLES (3)
  ) dut1 (
    .clk_i (clk), .rst_i (rst), .req_i (req[1]), .gnt_o (gnt[1]),
    .addr_i (addr[1]), .we_i (we[1]), .be_i (be[1]), .wdata_i (wdata[1]),
    .rvalid_o (rvalid[1]), .rdata_o (rdata[1]), .err_o (err[1])
  );

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  logic        allow_drop = 1'b0;
  logic [31:0] mdl [2][64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint base_of(input int d);
    return (d == 0) ? 64'h0 : 64'h1000;
  endfunction

  function automatic longint span_of(input int d);
    return (d == 0) ? 64'd4096 : 64'd64;
  endfunction

  function automatic int wc_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference memory: a plain word array indexed by (addr - base) / 4.
  task automatic model_acc(input int d, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e);
    longint off;
    int     i;
    off = longint'({32'h0, a}) - base_of(d);
    rd  = 32'h0;
    e   = 1'b0;
    if (off < 0 || off >= span_of(d)) begin
      e = 1'b1;
    end else begin
      i = int'(off / 4);
      if (w) begin
        for (int n = 0; n < 4; n++)
          if (b[n]) mdl[d][i][8*n +: 8] = wd[8*n +: 8];
      end else begin
        rd = mdl[d][i];
      end
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
    int          n;
    bit          got;
    logic [31:0] rd;
    logic        e;
    exp_t        x;
    n   = 0;
    got = 1'b0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt[d]) begin
        got = 1'b1;
        model_acc(d, w, a, b, wd, rd, e);
        x = '{d, rd, e, cyc + 1};
        sbq.push_back(x);
      end
      @(posedge clk);
      #1;
    end
    req[d] = 1'b0;
    chk($sformatf("grant latency dut%0d addr %h", d, a), 32'(n), 32'(wc_of(d) + 1));
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int r;
    r = $urandom_range(0, 9);
    if (d == 0) begin
      if (r == 0) return 32'h0000_1000 + ($urandom & 32'h0FFF_FFFF);
      return 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
    end
    if (r == 0) return 32'($urandom_range(0, 32'h0FFF));
    if (r == 1) return 32'h0000_1040 + 32'($urandom_range(0, 1000));
    return 32'h0000_1000 + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      if (rvalid[d] === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          total++;
          bad++;
          $display("FAIL unexpected rvalid dut%0d at cycle %0d: got 1 want 0", d, cyc);
        end else begin
          x = sbq.pop_front();
          chk($sformatf("rdata dut%0d", d), rdata[d], x.rdata);
          chk($sformatf("err dut%0d", d), 32'(err[d]), 32'(x.err));
          chk($sformatf("rvalid cycle dut%0d", d), 32'(cyc), 32'(x.due));
        end
      end
    end
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL missing rvalid dut%0d: got none want pulse at cycle %0d", sbq[0].dut, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  // Primary-side protocol: request and attributes held stable until grant.
  logic        pend   [2];
  logic [68:0] p_attr [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && !allow_drop && pend[d])
        assert (req[d] && {we[d], be[d], addr[d], wdata[d]} == p_attr[d])
          else $error("primary changed request before grant on dut%0d", d);
      pend[d]   <= req[d] && !gnt[d];
      p_attr[d] <= {we[d], be[d], addr[d], wdata[d]};
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; be[d] = 4'h0; wdata[d] = 32'h0;
      pend[d] = 1'b0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    req[0] = 1'b1;
    req[1] = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset gnt dut%0d", d), 32'(gnt[d]), 32'h0);
      chk($sformatf("reset rvalid dut%0d", d), 32'(rvalid[d]), 32'h0);
      chk($sformatf("reset rdata dut%0d", d), rdata[d], 32'h0);
      chk($sformatf("reset err dut%0d", d), 32'(err[d]), 32'h0);
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // preload the model-visible words with known data
    for (int i = 0; i < 64; i++) issue(0, 1'b1, 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 16; i++) issue(1, 1'b1, 32'h1000 + 32'(i * 4), 4'hF, $urandom);

    // write then read, no wait states
    issue(0, 1'b1, 32'h0000_0010, 4'hF, 32'hA5A5_1234);
    issue(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);

    // byte enables
    issue(0, 1'b1, 32'h0000_0014, 4'hF, 32'h1122_3344);
    issue(0, 1'b1, 32'h0000_0014, 4'b0101, 32'hFFFF_FFFF);
    issue(0, 1'b0, 32'h0000_0014, 4'h0, 32'h0);

    // back-to-back alternating write/read to one word
    for (int k = 0; k < 8; k++) issue(0, (k % 2 == 0), 32'h0000_0020, 4'hF, $urandom);

    // reset between a read's accept edge and its response
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0010; be[0] = 4'hF;
    @(negedge clk);
    chk("reset-test grant", 32'(gnt[0]), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid-reset rvalid", 32'(rvalid[0]), 32'h0);
    chk("mid-reset rdata", rdata[0], 32'h0);
    chk("mid-reset err", 32'(err[0]), 32'h0);
    chk("mid-reset gnt", 32'(gnt[0]), 32'h0);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    issue(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);

    // wait states with req held
    issue(1, 1'b0, 32'h0000_1000, 4'h0, 32'h0);

    // request withdrawn after two cycles of waiting
    allow_drop = 1'b1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_1008; be[1] = 4'hF; wdata[1] = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("withdrawn request gnt", 32'(gnt[1]), 32'h0);
      @(posedge clk);
      #1;
    end
    req[1] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    allow_drop = 1'b0;
    issue(1, 1'b0, 32'h0000_1008, 4'h0, 32'h0);

    // out of range around a 16-word window at 0x1000
    issue(1, 1'b1, 32'h0000_1040, 4'hF, 32'hDEAD_BEEF);
    issue(1, 1'b0, 32'h0000_1040, 4'h0, 32'h0);
    issue(1, 1'b0, 32'h0000_0FFC, 4'h0, 32'h0);
    issue(1, 1'b0, 32'h0000_103C, 4'h0, 32'h0);

    // randomized traffic
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        issue(d, 1'($urandom_range(0, 1)), rand_addr(d), 4'($urandom_range(0, 15)), $urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
